// File: rtl/rpm_meas_ctrl.sv
// Index-channel RPM sequencer: times revolutions in 1 ms ticks, averages a window
// of periods, runs one division per window through a shared divider, publishes RPM.
module rpm_meas_ctrl #(
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_MS    = 5000,
    parameter int MIN_PERIOD_MS = 10,
    parameter int AVG_LOG2      = 2,
    parameter int RPM_CONST     = 60000,
    parameter int RPM_W         = 17
) (
    input  logic                      clk_1ms,
    input  logic                      RST,
    input  logic                      en,
    input  logic                      idx_pulse,
    output logic                      div_req,
    output logic [31:0]               div_num,
    output logic [CNT_W+AVG_LOG2-1:0] div_den,
    input  logic                      div_ack,
    input  logic [31:0]               div_quot,
    output logic [RPM_W-1:0]          rpm,
    output logic                      rpm_valid,
    output logic                      stalled,
    output logic                      overrun
);
    localparam int                DEN_W     = CNT_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] NPER_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]  TO_CNT    = CNT_W'(TIMEOUT_MS);
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PERIOD_MS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]       DIV_NUM   = 32'(RPM_CONST) << AVG_LOG2;
    localparam logic [RPM_W-1:0]  RPM_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    typedef enum logic {D_IDLE, D_REQ} dstate_t;

    state_t            state;
    dstate_t           dstate;
    logic [CNT_W-1:0]  cnt;
    logic [DEN_W-1:0]  acc;
    logic [AVG_LOG2:0] nper;

    logic             timeout, period_ok, win_done, publish;
    logic [DEN_W-1:0] sum;
    logic [RPM_W-1:0] quot_sat;

    assign timeout   = (state != IDLE) && (cnt == TO_CNT);
    // A pulse landing on the timeout cycle re-arms instead of closing a period.
    assign period_ok = idx_pulse && (state == MEASURE) && (cnt >= MIN_CNT) && !timeout;
    assign sum       = acc + DEN_W'(cnt);
    assign win_done  = period_ok && (nper == NPER_LAST);
    assign publish   = (dstate == D_REQ) && div_ack && !stalled && !timeout;
    assign quot_sat  = (div_quot > 32'(RPM_MAX)) ? RPM_MAX : div_quot[RPM_W-1:0];

    always_ff @(posedge clk_1ms or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dstate    <= D_IDLE;
            cnt       <= '0;
            acc       <= '0;
            nper      <= '0;
            div_req   <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            rpm       <= '0;
            rpm_valid <= 1'b0;
            stalled   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rpm_valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                dstate  <= D_IDLE;
                div_req <= 1'b0;
                rpm     <= '0;
                acc     <= '0;
                nper    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= CNT_ONE;
                    end
                    default: begin
                        if (cnt != TO_CNT)
                            cnt <= cnt + 1'b1;
                        if (timeout) begin
                            if (!stalled) begin
                                rpm       <= '0;
                                rpm_valid <= 1'b1;
                                stalled   <= 1'b1;
                            end
                            acc   <= '0;
                            nper  <= '0;
                            state <= ARM;
                            if (idx_pulse) begin
                                state <= MEASURE;
                                cnt   <= CNT_ONE;
                            end
                        end else if (state == ARM) begin
                            if (idx_pulse) begin
                                state <= MEASURE;
                                cnt   <= CNT_ONE;
                            end
                        end else if (period_ok) begin
                            cnt     <= CNT_ONE;
                            stalled <= 1'b0;
                            if (win_done) begin
                                acc  <= '0;
                                nper <= '0;
                            end else begin
                                acc  <= sum;
                                nper <= nper + 1'b1;
                            end
                        end
                    end
                endcase

                case (dstate)
                    D_IDLE: begin
                        if (win_done) begin
                            div_den <= sum;
                            div_num <= DIV_NUM;
                            div_req <= 1'b1;
                            dstate  <= D_REQ;
                        end
                    end
                    default: begin
                        // Windows closing while a division is outstanding are lost.
                        if (win_done)
                            overrun <= 1'b1;
                        if (div_ack) begin
                            div_req <= 1'b0;
                            dstate  <= D_IDLE;
                            if (publish) begin
                                rpm       <= quot_sat;
                                rpm_valid <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/rpm_meas_ctrl.md
Name: rpm_meas_ctrl

Overview:
Measurement sequencer for the index-channel (ChZ) RPM path. It times revolutions in 1 ms ticks, rejects glitch pulses, and averages a window of 2^AVG_LOG2 periods. It sequences one division per window through a shared divider via a req/ack handshake, then publishes RPM, with a zero-speed result on timeout. It sits between the synchronised index strobe and the display/ASCII digit stage.

Parameters:
CNT_W, 16, width of the period counter
TIMEOUT_MS, 5000, period count at which the shaft is declared stalled
MIN_PERIOD_MS, 10, accepted index pulses need a period >= this value; shorter ones are ignored
AVG_LOG2, 2, window of 2^AVG_LOG2 periods per result
RPM_CONST, 60000, ms per minute
RPM_W, 17, width of the RPM result

Ports:
clk_1ms  in  1  1 ms tick clock
RST  in  1  asynchronous, active-high reset
en  in  1  measurement enable
idx_pulse  in  1  one-cycle index strobe, synchronous to clk_1ms
div_req  out  1  divider request, level
div_num  out  32  dividend, equal to RPM_CONST << AVG_LOG2
div_den  out  CNT_W+AVG_LOG2  divisor, the window period sum
div_ack  in  1  one-cycle divider completion
div_quot  in  32  divider quotient, valid with div_ack
rpm  out  RPM_W  last published RPM
rpm_valid  out  1  one-cycle publish strobe
stalled  out  1  shaft declared stopped
overrun  out  1  sticky flag: a window was dropped while the divider was busy

Behaviour:
- Reset values: every output is 0. The main FSM is IDLE, the divider FSM is D_IDLE, and cnt, acc and nper are 0.
- Main FSM states: IDLE, ARM, MEASURE.
- IDLE -> ARM when en=1. cnt is loaded with 1.
- In any state, en=0 -> IDLE next cycle. On that transition: rpm<=0, div_req<=0, the divider FSM returns to D_IDLE, and acc and nper are cleared. overrun is kept.
- cnt behaviour in ARM and MEASURE: it increments by 1 per cycle and saturates at TIMEOUT_MS.
- An idx_pulse is accepted when cnt >= MIN_PERIOD_MS in MEASURE, or unconditionally in ARM. An accepted pulse loads cnt with 1. The period equals the cnt value in the cycle the pulse is asserted.
- ARM, on accepted idx -> MEASURE. No period is recorded.
- MEASURE, on accepted idx: acc += cnt, nper += 1. stalled <= 0.
- When nper reaches 2^AVG_LOG2 (window complete), the final sum is handed to the divider FSM, and acc and nper restart from 0 in that same cycle.
- Rejected pulses in MEASURE (cnt < MIN_PERIOD_MS) change nothing.
- Timeout: when cnt == TIMEOUT_MS in ARM or MEASURE:
  - if stalled=0: rpm<=0, rpm_valid pulses, stalled<=1;
  - acc and nper are cleared, state -> ARM, and cnt stays saturated.
- If an idx_pulse coincides with the timeout cycle, the timeout action occurs and the pulse is the ARM pulse: state -> MEASURE, cnt<=1.
- Divider FSM, D_IDLE:
  - on window complete: div_den <= sum, div_num <= RPM_CONST << AVG_LOG2, div_req <= 1 (next cycle) -> D_REQ.
- Divider FSM, D_REQ:
  - div_num, div_den and div_req are held stable until div_ack.
  - On div_ack: div_req <= 0, rpm <= div_quot (saturated to 2^RPM_W - 1 if larger), rpm_valid pulses the next cycle, -> D_IDLE.
  - A window completing while in D_REQ is discarded and overrun <= 1.
  - A window completing in the same cycle as div_ack is also discarded (it counts as an overrun).
- div_ack outside D_REQ is ignored.
- Timeout while in D_REQ: the request stays pending. When div_ack arrives, the quotient is discarded (no publish) because stalled=1.
- rpm_valid never pulses twice in one cycle. If a timeout and a div_ack publish coincide, the timeout wins.
- Latency: the accepted idx that completes a window is followed by div_req one cycle later. rpm_valid follows one cycle after div_ack.
- div_den width is CNT_W+AVG_LOG2 bits, so the sum never overflows, because each period is <= TIMEOUT_MS < 2^CNT_W.

Test Plan:
- Reset, then en=1 with idx every 100 ms → after the 5th pulse (1 arm + 4 periods), div_den=400 and div_num=240000. Return div_ack with div_quot=600 → rpm=600, rpm_valid for 1 cycle, stalled=0.
- Extra idx pulse 5 ms after an accepted one, during 100 ms periods → pulse ignored, div_den still 400.
- Stop idx pulses after a valid result → 5000 cycles after the last accepted pulse, rpm=0, rpm_valid once, stalled=1. No further rpm_valid while stopped.
- Hold div_ack low for 500 cycles with idx every 100 ms → div_req, div_num and div_den stay stable. The second window is dropped, and overrun=1 (sticky).
- Drop en mid-request, then assert div_ack → div_req=0 next cycle, rpm=0, ack ignored, no rpm_valid.
- Assert RST asynchronously mid-MEASURE → all outputs 0 immediately. With en=1 after release, the FSM is in ARM and the first pulse produces no period.
